// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths and the writeback arbiter pointer state.
package cpu_pkg;
  localparam int REG_IDX_W = 4;
  localparam int NREGS     = 16;
  localparam int DATA_W    = 32;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } arb_state_t;
endpackage

// File: rtl/reg_write_arbiter_if.sv
// Writeback requester handshakes plus the registered write port toward the bank.
interface reg_write_arbiter_if #(
  parameter int NREGS = 16,
  parameter int DW    = 32
);
  import cpu_pkg::*;

  logic                 stall;
  logic                 wr0_valid;
  logic [REG_IDX_W-1:0] wr0_dest;
  logic [DW-1:0]        wr0_data;
  logic                 wr0_ready;
  logic                 wr1_valid;
  logic [REG_IDX_W-1:0] wr1_dest;
  logic [DW-1:0]        wr1_data;
  logic                 wr1_ready;
  logic [NREGS-1:0]     reg_we;
  logic [REG_IDX_W-1:0] reg_waddr;
  logic [DW-1:0]        reg_wdata;
  logic                 last_grant;

  modport master (
    output stall, wr0_valid, wr0_dest, wr0_data, wr1_valid, wr1_dest, wr1_data,
    input  wr0_ready, wr1_ready, reg_we, reg_waddr, reg_wdata, last_grant
  );

  modport slave (
    input  stall, wr0_valid, wr0_dest, wr0_data, wr1_valid, wr1_dest, wr1_data,
    output wr0_ready, wr1_ready, reg_we, reg_waddr, reg_wdata, last_grant
  );
endinterface

// File: rtl/reg_dest_decoder.sv
// Register index to one-hot bank write enable; purely combinational.
module reg_dest_decoder
  import cpu_pkg::*;
(
  input  logic [REG_IDX_W-1:0] idx,
  output logic [NREGS-1:0]     onehot
);
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port between ALU and load writeback.
// Ready is combinational from valid/state/stall; the bank sees the write one cycle after the grant.
module reg_write_arbiter #(
  parameter int NREGS = 16,
  parameter int DW    = 32
) (
  input logic               clk,
  input logic               rst_n,
  reg_write_arbiter_if.slave bus
);
  import cpu_pkg::*;

  arb_state_t           state;
  logic                 last_grant_q;
  logic                 grant0;
  logic                 grant1;
  logic                 any_grant;
  logic [REG_IDX_W-1:0] sel_dest;
  logic [DW-1:0]        sel_data;
  logic [NREGS-1:0]     dec_we;
  logic [NREGS-1:0]     we_q;
  logic [REG_IDX_W-1:0] waddr_q;
  logic [DW-1:0]        wdata_q;

  // rst_n gating keeps requesters from seeing a handshake while the bank path is held in reset.
  always_comb begin
    grant0 = rst_n & ~bus.stall & bus.wr0_valid & (~bus.wr1_valid | (state == PRI0));
    grant1 = rst_n & ~bus.stall & bus.wr1_valid & (~bus.wr0_valid | (state == PRI1));
  end

  assign any_grant = grant0 | grant1;
  assign sel_dest  = grant1 ? bus.wr1_dest : bus.wr0_dest;
  assign sel_data  = grant1 ? bus.wr1_data : bus.wr0_data;

  reg_dest_decoder u_dec (
    .idx    (sel_dest),
    .onehot (dec_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PRI0;
      last_grant_q <= 1'b1;
    end else if (grant0) begin
      state        <= PRI1;
      last_grant_q <= 1'b0;
    end else if (grant1) begin
      state        <= PRI0;
      last_grant_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= any_grant ? dec_we : '0;
      if (any_grant) begin
        waddr_q <= sel_dest;
        wdata_q <= sel_data;
      end
    end
  end

  assign bus.wr0_ready  = grant0;
  assign bus.wr1_ready  = grant1;
  assign bus.reg_we     = we_q;
  assign bus.reg_waddr  = waddr_q;
  assign bus.reg_wdata  = wdata_q;
  assign bus.last_grant = last_grant_q;
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the register bank's single write port between two writeback requesters: port 0 (ALU result) and port 1 (load data). Round-robin arbitration with valid/ready handshakes, one grant per cycle. The winning 4-bit destination is decoded to the bank's 16-bit one-hot write enable, and address, enable and data are registered toward the bank. Sits between the execute/memory writeback paths and the register bank.

## Interface
- `NREGS`, 16: registers in the bank; one-hot width. Fixed at 16 here.
- `DW`, 32: data width.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: when high, no grant is issued this cycle.
- `wr0_valid` in 1: ALU write request.
- `wr0_dest` in 4: ALU destination register.
- `wr0_data` in DW: ALU write data.
- `wr0_ready` out 1: ALU request accepted this cycle (combinational).
- `wr1_valid`, `wr1_dest`, `wr1_data`, `wr1_ready`: same as port 0, for the load path.
- `reg_we` out 16: registered one-hot write enable to the bank; bit n writes register n.
- `reg_waddr` out 4: registered destination index.
- `reg_wdata` out DW: registered write data.
- `last_grant` out 1: RR pointer; port granted most recently.

## Operation
- Pointer FSM with two states:
  - PRI0 (port 0 favoured) is the reset state.
  - PRI1 (port 1 favoured).
- Grant rules:
  - Only one valid: that port wins, regardless of state.
  - Both valid: the favoured port wins.
  - After any grant, the state moves to favour the other port: grant 0 goes to PRI1, grant 1 goes to PRI0.
  - No grant: state holds.
- `wrN_ready = wrN_valid & grantN & ~stall`. A transfer happens on the cycle where valid and ready are both high.
- A requester holds valid, dest and data stable until it sees ready. The arbiter does not buffer losers.
- `stall` high: both readies are 0, the FSM holds, and `reg_we` is 0 on the next cycle.
- Output register on each edge:
  - `reg_we` becomes the one-hot decode of the granted dest (dest 0 gives 16'h0001, dest 15 gives 16'h8000), or 0 if no grant.
  - `reg_waddr` and `reg_wdata` load only on a grant; otherwise they hold.
- Register 0 is an ordinary writable register; no special case.
- Both ports targeting the same dest in one cycle: the favoured port writes first and the other writes on its next grant. Bank order equals grant order, so the later grant wins.
- `last_grant` is 0 in PRI1 (port 0 granted last) and 1 in PRI0 after a port-1 grant. Reset value is 1.

## Timing
- Grant to `reg_we` at the bank: 1 cycle.
- `wrN_ready` is combinational from valid, FSM state and stall. There is no path from ready back into valid.
- Throughput: one write per cycle.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1 starting with port 0 after reset.
- Reset values: `reg_we`=0, `reg_waddr`=0, `reg_wdata`=0, state PRI0, `last_grant`=1.
- Reset asserted mid-transfer: outputs clear immediately, without waiting for a clock edge. The in-flight write is lost, and requesters re-present it after reset.
- `stall` deasserting: arbitration resumes the same cycle using the held FSM state.

## Structure
- Shared package `cpu_pkg` holds:
  - `REG_IDX_W` = 4.
  - `NREGS` = 16.
  - `DATA_W` = 32.
  - the state enum `arb_state_t` {PRI0, PRI1}.
- Sub-module `reg_dest_decoder` converts a 4-bit index to a 16-bit one-hot enable. It is purely combinational and reused wherever the bank's enable is generated.
- Top level contains the FSM, the grant logic and the output register.

## Test plan
- Reset: hold `rst_n`=0 with both ports valid. Require `reg_we`=0, `reg_wdata`=0, both readies 0 and `last_grant`=1. Release reset; the first grant goes to port 0.
- Single port: `wr1_valid`=1, dest=4'hA, data=32'hDEADBEEF. Require `wr1_ready`=1 that cycle, then next cycle `reg_we`=16'h0400, `reg_waddr`=4'hA, `reg_wdata`=32'hDEADBEEF.
- Contention: both ports valid for 4 cycles (port 0 dest 3, port 1 dest 7). Required grants are 0,1,0,1, and `reg_we` alternates 16'h0008 and 16'h0080.
- Same dest: both ports target dest 5, with data0=32'h1 and data1=32'h2, from PRI0. Require a port-0 write then a port-1 write, so register 5 ends at 32'h2.
- Stall: assert `stall` for 3 cycles with both ports valid. Require readies 0, `reg_we`=0 from the next cycle, and the FSM state unchanged. After release, the favoured port is granted first.
- Async reset mid-stream: drop `rst_n` between clock edges during alternating grants. Require outputs to clear before the next edge and the state to return to PRI0.
